// File: rtl/ioctl_router_pkg.sv
// Shared types and defaults for the ioctl ROM router: FSM states, default
// download indices and counter-width helpers.
package ioctl_router_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        TAIL,
        RUN
    } router_state_t;

    localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
    localparam logic [7:0] MOD_INDEX_DEF = 8'd1;
    localparam logic [7:0] DIP_INDEX_DEF = 8'd254;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ioctl_region_match.sv
// Combinational address decoder: maps a download address onto NREG regions,
// returning a one-hot hit (lowest index wins on overlap) and the local offset.
module ioctl_region_match #(
    parameter int                       NREG     = 3,
    parameter int                       AW       = 25,
    parameter int                       LAW      = 16,
    parameter logic [NREG*AW-1:0]       REG_BASE = '0,
    parameter logic [NREG*(LAW+1)-1:0]  REG_SIZE = '0
) (
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] hit,
    output logic [LAW-1:0]  offset
);

    logic [NREG-1:0] in_range;
    logic [LAW-1:0]  off [NREG];

    // One extra bit on every bound so a region ending at 2**AW cannot wrap.
    for (genvar i = 0; i < NREG; i++) begin : g_region
        localparam logic [AW:0] LO = {1'b0, REG_BASE[i*AW +: AW]};
        localparam logic [AW:0] HI = LO + (AW+1)'(REG_SIZE[i*(LAW+1) +: LAW+1]);

        assign in_range[i] = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
        assign off[i]      = LAW'({1'b0, addr} - LO);
    end

    // NOTE: defaults first so every path assigns hit/offset and no latch is inferred.
    always_comb begin
        hit    = '0;
        offset = '0;
        for (int k = NREG - 1; k >= 0; k--) begin
            if (in_range[k]) begin
                hit    = '0;
                hit[k] = 1'b1;
                offset = off[k];
            end
        end
    end

endmodule

// File: rtl/ioctl_rom_router.sv
// Routes the hps_io ROM download into per-region dpram write ports, captures
// DIP/mod bytes and holds the core in reset until the ROM load has settled.
module ioctl_rom_router
    import ioctl_router_pkg::*;
#(
    parameter int                       NREG      = 3,
    parameter int                       AW        = 25,
    parameter int                       LAW       = 16,
    parameter logic [NREG*AW-1:0]       REG_BASE  = {25'hFF00, 25'hE000, 25'h0},
    parameter logic [NREG*(LAW+1)-1:0]  REG_SIZE  = {17'h100, 17'h1000, 17'h8000},
    parameter logic [7:0]               ROM_INDEX = ROM_INDEX_DEF,
    parameter logic [7:0]               MOD_INDEX = MOD_INDEX_DEF,
    parameter logic [7:0]               DIP_INDEX = DIP_INDEX_DEF,
    parameter int                       NDIP      = 8,
    parameter int                       HOLD      = 16
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr,
    input  logic [AW-1:0]       ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic [NREG-1:0]     rom_we,
    output logic [LAW-1:0]      rom_addr,
    output logic [7:0]          rom_data,
    output logic [NDIP*8-1:0]   dip_sw,
    output logic [7:0]          mod,
    output logic                core_reset,
    output logic                load_done,
    output logic                load_ok,
    output logic [NREG-1:0]     region_full
);

    localparam int TW = cnt_width(HOLD + 1);

    router_state_t   state, state_next;
    logic [TW-1:0]   tail_cnt;
    logic            armed;
    logic [NREG-1:0] hit;
    logic [LAW-1:0]  offset;
    logic [LAW:0]    cnt [NREG];
    logic [NREG-1:0] full_now;
    logic            start_load, rom_wr, tail_done, enter_load, end_load;

    ioctl_region_match #(
        .NREG     (NREG),
        .AW       (AW),
        .LAW      (LAW),
        .REG_BASE (REG_BASE),
        .REG_SIZE (REG_SIZE)
    ) u_match (
        .addr   (ioctl_addr),
        .hit    (hit),
        .offset (offset)
    );

    // armed is cleared by reset and only set once ioctl_download has been seen low,
    // so a download already running at reset release cannot start a load.
    assign start_load = armed && ioctl_download && (ioctl_index == ROM_INDEX);
    assign rom_wr     = (state == LOAD) && ioctl_download && ioctl_wr && (ioctl_index == ROM_INDEX);
    assign tail_done  = (int'(tail_cnt) + 1 >= HOLD);
    assign enter_load = (state_next == LOAD) && (state != LOAD);
    assign end_load   = (state == LOAD) && (state_next == TAIL);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RUN: if (start_load)      state_next = LOAD;
            LOAD:      if (!ioctl_download) state_next = TAIL;
            TAIL:      if (tail_done)       state_next = RUN;
            default:                        state_next = IDLE;
        endcase
    end

    always_comb begin
        full_now = '0;
        for (int i = 0; i < NREG; i++)
            full_now[i] = (cnt[i] == REG_SIZE[i*(LAW+1) +: LAW+1]);
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tail_cnt    <= '0;
            armed       <= 1'b0;
            rom_we      <= '0;
            rom_addr    <= '0;
            rom_data    <= '0;
            dip_sw      <= '0;
            mod         <= '0;
            core_reset  <= 1'b1;
            load_done   <= 1'b0;
            load_ok     <= 1'b0;
            region_full <= '0;
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            state      <= state_next;
            tail_cnt   <= (state == TAIL) ? tail_cnt + 1'b1 : '0;
            core_reset <= (state != RUN);

            if (!ioctl_download)  armed <= 1'b1;
            else if (enter_load)  armed <= 1'b0;

            rom_we <= rom_wr ? hit : '0;
            if (rom_wr && |hit) begin
                rom_addr <= offset;
                rom_data <= ioctl_dout;
            end

            // Counters saturate at the region size, so rewrites never overflow them.
            for (int i = 0; i < NREG; i++) begin
                if (enter_load)
                    cnt[i] <= '0;
                else if (rom_wr && hit[i] && !full_now[i])
                    cnt[i] <= cnt[i] + 1'b1;
            end

            if (end_load) begin
                region_full <= full_now;
                load_ok     <= &full_now;
                load_done   <= 1'b1;
            end

            for (int k = 0; k < NDIP; k++) begin
                if (ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr == AW'(k)))
                    dip_sw[k*8 +: 8] <= ioctl_dout;
            end

            if (ioctl_wr && (ioctl_index == MOD_INDEX))
                mod <= ioctl_dout;
        end
    end

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Directed bench for ioctl_rom_router: full/truncated ROM loads, reset hold,
// DIP/mod capture, reset mid-load and overlapping region priority.
module tb_ioctl_rom_router;

    localparam int NREG = 3;
    localparam int AW   = 25;
    localparam int LAW  = 16;
    localparam int NDIP = 8;
    localparam int HOLD = 16;
    localparam logic [7:0] ROM_IDX = 8'd0;
    localparam logic [7:0] MOD_IDX = 8'd1;
    localparam logic [7:0] DIP_IDX = 8'd254;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [AW-1:0]     ioctl_addr;
    logic [7:0]        ioctl_dout;

    logic [NREG-1:0]   rom_we, ov_rom_we;
    logic [LAW-1:0]    rom_addr, ov_rom_addr;
    logic [7:0]        rom_data, ov_rom_data;
    logic [NDIP*8-1:0] dip_sw, ov_dip_sw;
    logic [7:0]        mod, ov_mod;
    logic              core_reset, ov_core_reset;
    logic              load_done, ov_load_done;
    logic              load_ok, ov_load_ok;
    logic [NREG-1:0]   region_full, ov_region_full;

    int n_checks = 0;
    int n_fail   = 0;
    int beats [NREG];
    int beat_err;

    always #5 clk_sys = ~clk_sys;

    ioctl_rom_router dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .dip_sw         (dip_sw),
        .mod            (mod),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .load_ok        (load_ok),
        .region_full    (region_full)
    );

    // Overlapping layout: regions 0 and 1 share 'h10..'h1F.
    ioctl_rom_router #(
        .REG_BASE ({25'h100, 25'h10, 25'h0}),
        .REG_SIZE ({17'h10, 17'h20, 17'h20})
    ) dut_ov (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_we         (ov_rom_we),
        .rom_addr       (ov_rom_addr),
        .rom_data       (ov_rom_data),
        .dip_sw         (ov_dip_sw),
        .mod            (ov_mod),
        .core_reset     (ov_core_reset),
        .load_done      (ov_load_done),
        .load_ok        (ov_load_ok),
        .region_full    (ov_region_full)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_we(input int a);
        if (a < 'h8000)                 return 3'b001;
        if (a >= 'hE000 && a < 'hF000)  return 3'b010;
        if (a >= 'hFF00 && a < 'h10000) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [15:0] exp_off(input int a);
        if (a < 'h8000)  return 16'(a);
        if (a < 'hF000)  return 16'(a - 'hE000);
        return 16'(a - 'hFF00);
    endfunction

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'(a >> 8);
    endfunction

    task automatic clear_tally();
        for (int k = 0; k < NREG; k++) beats[k] = 0;
        beat_err = 0;
    endtask

    // One ROM byte per cycle; each beat's registered output is checked 1 after the next edge.
    task automatic stream(input int lo, input int hi, input bit live);
        logic [2:0] ew;
        for (int a = lo; a <= hi; a++) begin
            ioctl_index = ROM_IDX;
            ioctl_wr    = 1'b1;
            ioctl_addr  = AW'(a);
            ioctl_dout  = pat(a);
            @(posedge clk_sys); #1;
            ew = live ? exp_we(a) : 3'b000;
            if (rom_we !== ew) beat_err++;
            else if (ew != 3'b000 && (rom_addr !== exp_off(a) || rom_data !== pat(a))) beat_err++;
            for (int k = 0; k < NREG; k++) if (rom_we[k] === 1'b1) beats[k]++;
        end
        ioctl_wr = 1'b0;
        @(posedge clk_sys); #1;
        if (rom_we !== 3'b000) beat_err++;
    endtask

    task automatic wr_byte(input logic [7:0] idx, input int a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = AW'(a);
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr    = 1'b0;
    endtask

    // Counts cycles core_reset stays high, bounded at 100.
    task automatic wait_core_run(output int n);
        n = 0;
        while (core_reset && n < 100) begin
            @(posedge clk_sys); #1;
            if (core_reset) n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
        ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = 8'd0;
        repeat (2) @(posedge clk_sys); #1;

        check("rst_rom_we",      rom_we,      0);
        check("rst_rom_addr",    rom_addr,    0);
        check("rst_rom_data",    rom_data,    0);
        check("rst_dip_sw",      dip_sw,      0);
        check("rst_mod",         mod,         0);
        check("rst_core_reset",  core_reset,  1);
        check("rst_load_done",   load_done,   0);
        check("rst_load_ok",     load_ok,     0);
        check("rst_region_full", region_full, 0);

        reset = 1'b0;
        repeat (2) @(posedge clk_sys); #1;
        check("idle_core_reset", core_reset, 1);

        // Full load covering every region plus the gaps around them.
        ioctl_index = ROM_IDX; ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        clear_tally();
        stream(0, 'h800F, 1'b1);
        stream('hDFF0, 'hF00F, 1'b1);
        stream('hFEF0, 'h10003, 1'b1);
        check("full_beats0", beats[0], 'h8000);
        check("full_beats1", beats[1], 'h1000);
        check("full_beats2", beats[2], 'h100);
        check("full_beat_err", beat_err, 0);
        check("load_done_during_load", load_done, 0);
        ioctl_download = 1'b0;
        wait_core_run(n);
        check("hold_cycles", n, HOLD + 1);
        check("run_core_reset", core_reset, 0);
        check("full_load_done", load_done, 1);
        check("full_load_ok", load_ok, 1);
        check("full_region_full", region_full, 3'b111);

        // Truncated reload: region 2 never written.
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        clear_tally();
        stream(0, 'h7FFF, 1'b1);
        stream('hE000, 'hEFFF, 1'b1);
        check("trunc_beats0", beats[0], 'h8000);
        check("trunc_beats1", beats[1], 'h1000);
        check("trunc_beats2", beats[2], 0);
        check("trunc_beat_err", beat_err, 0);
        ioctl_download = 1'b0;
        wait_core_run(n);
        check("trunc_hold_cycles", n, HOLD + 1);
        check("trunc_region_full", region_full, 3'b011);
        check("trunc_load_ok", load_ok, 0);
        check("trunc_load_done", load_done, 1);

        // DIP capture, including the last valid and first invalid address.
        ioctl_index = DIP_IDX; ioctl_download = 1'b1;
        wr_byte(DIP_IDX, 0, 8'hA5);
        check("dip_no_rom_we", rom_we, 0);
        wr_byte(DIP_IDX, 9, 8'h3C);
        wr_byte(DIP_IDX, 7, 8'h77);
        wr_byte(DIP_IDX, 8, 8'hEE);
        ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        check("dip_sw", dip_sw, 64'h7700_0000_0000_00A5);

        ioctl_index = MOD_IDX; ioctl_download = 1'b1;
        wr_byte(MOD_IDX, 0, 8'h09);
        wr_byte(MOD_IDX, 0, 8'h02);
        ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        check("mod_last_wins", mod, 8'h02);

        wr_byte(ROM_IDX, 'h10, 8'h55);
        check("wr_without_download", rom_we, 0);
        check("other_index_keeps_run", core_reset, 0);

        // Async reset in the middle of a load.
        ioctl_index = ROM_IDX; ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        clear_tally();
        stream('h3FF8, 'h3FFF, 1'b1);
        check("pre_reset_beat_err", beat_err, 0);
        ioctl_wr = 1'b1; ioctl_addr = AW'('h4000); ioctl_dout = 8'h40;
        @(posedge clk_sys); #1;
        check("pre_reset_rom_we", rom_we, 3'b001);
        reset = 1'b1;
        #1;
        check("mid_rst_rom_we",      rom_we,      0);
        check("mid_rst_rom_addr",    rom_addr,    0);
        check("mid_rst_dip_sw",      dip_sw,      0);
        check("mid_rst_mod",         mod,         0);
        check("mid_rst_core_reset",  core_reset,  1);
        check("mid_rst_load_done",   load_done,   0);
        check("mid_rst_region_full", region_full, 0);
        ioctl_wr = 1'b0;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        clear_tally();
        stream('h4001, 'h4020, 1'b0);
        check("no_rearm_beat_err", beat_err, 0);
        check("no_rearm_core_reset", core_reset, 1);
        ioctl_download = 1'b0;
        repeat (3) @(posedge clk_sys); #1;
        check("no_rearm_load_done", load_done, 0);
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        clear_tally();
        stream('h4000, 'h4003, 1'b1);
        check("rearm_beats0", beats[0], 4);
        check("rearm_beat_err", beat_err, 0);

        // Overlap priority on the second instance, same download.
        wr_byte(ROM_IDX, 'h18, 8'hC3);
        check("ov_we_18",   ov_rom_we,   3'b001);
        check("ov_addr_18", ov_rom_addr, 16'h18);
        check("ov_data_18", ov_rom_data, 8'hC3);
        wr_byte(ROM_IDX, 'h2F, 8'h2F);
        check("ov_we_2f",   ov_rom_we,   3'b010);
        check("ov_addr_2f", ov_rom_addr, 16'h1F);
        wr_byte(ROM_IDX, 'h30, 8'h30);
        check("ov_we_30",   ov_rom_we,   3'b000);
        wr_byte(ROM_IDX, 'h10F, 8'h0F);
        check("ov_we_10f",   ov_rom_we,   3'b100);
        check("ov_addr_10f", ov_rom_addr, 16'h0F);
        ioctl_download = 1'b0;
        repeat (2) @(posedge clk_sys); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
